dir_arbiter: RTL and testbench
==============================

DIR_ARBITER -- requirements
Module: dir_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum WAIT cycles before abort (valid range 4..255).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  4  per-requester request valid, index i = requester i.
REQ-005 SHALL have req_ready  output  4  per-requester accept strobe, at most one bit set.
REQ-006 SHALL have req_op  input  4  per-requester operation, 0 = lookup, 1 = update.
REQ-007 SHALL have req_addr  input  128  requester i address in bits [32i+31:32i].
REQ-008 SHALL have req_state  input  12  requester i new directory state in bits [3i+2:3i].
REQ-009 SHALL have req_presence / req_tip  input  16 each  requester i vectors in bits [4i+3:4i].
REQ-010 SHALL have rsp_valid  output  4  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have rsp_state  output  3; rsp_presence, rsp_tip  output  4 each; rsp_err  output  1: shared response payload, valid only while any rsp_valid bit is set.
REQ-012 SHALL have dir_lookup_req, dir_update_req  output  1; dir_lookup_addr, dir_update_addr  output  32; dir_update_state  output  3; dir_update_presence, dir_update_tip  output  4: directory command port.
REQ-013 SHALL have dir_lookup_valid, dir_update_done  input  1; dir_lookup_state  input  3; dir_lookup_presence, dir_lookup_tip  input  4: directory completion port.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-015 In IDLE with any req_valid set, SHALL grant requester g chosen round-robin, searching from (last_grant+1) mod 4 upward with wrap-around.
REQ-016 SHALL drive req_ready[g]=1 combinationally in that IDLE cycle only, capture op/addr/state/presence/tip of g into registers, update last_grant to g, go to ISSUE.
REQ-017 req_ready SHALL be 0 in ISSUE, WAIT, RESP; requests arriving then SHALL remain pending, with no loss.
REQ-018 In ISSUE SHALL assert exactly one of dir_lookup_req / dir_update_req (per captured op) for exactly one cycle, then go to WAIT.
REQ-019 dir_lookup_addr and dir_update_addr SHALL both carry the captured address from ISSUE through WAIT; the other command strobe SHALL stay 0.
REQ-020 dir_update_state/presence/tip SHALL hold the captured values from ISSUE until completion, because the directory samples them one cycle after the command.
REQ-021 In WAIT SHALL accept only the completion matching op: dir_lookup_valid for lookup, dir_update_done for update; the non-matching completion SHALL be ignored.
REQ-022 On matching completion SHALL register the response: lookup gives dir_lookup_state/presence/tip; update gives the captured update state/presence/tip. rsp_err SHALL be 0. Then go to RESP.
REQ-023 WAIT counter SHALL clear on entry and increment each WAIT cycle; when it reaches TIMEOUT_CYCLES with no completion, go to RESP with rsp_err=1, rsp_state=0, vectors=0.
REQ-024 In RESP SHALL assert rsp_valid[g] for exactly one cycle, then return to IDLE; rsp_* SHALL hold their value until the next RESP.
REQ-025 Nominal latency: grant at cycle T, directory command at T+1, directory completion at T+3, rsp_valid at T+4, next grant possible at T+5.
REQ-026 Completion inputs arriving in IDLE, ISSUE or RESP SHALL be ignored.
REQ-027 A requester SHALL NOT be granted again before its rsp_valid pulse; with all four requesting continuously, the grant order SHALL be 0,1,2,3,0,...

Reset
REQ-028 While rst_n=0, all outputs SHALL be 0, FSM SHALL be IDLE, counter SHALL be 0, and last_grant SHALL be 3 so requester 0 has first priority.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no rsp_valid pulse; a completion arriving after reset release SHALL be ignored per REQ-026.

Verification
REQ-030 Lookup: req_valid=0001, op=0, addr0=0x0000_1044; directory returns state=2, presence=0101, tip=0001 at T+3 -> rsp_valid=0001 at T+4 with rsp_state=2, rsp_presence=0101, rsp_tip=0001, rsp_err=0.
REQ-031 Update: req_valid=0100, op=1, addr2=0x8000_0007, state=3, presence=1000, tip=1000 -> dir_update_req pulse at T+1, dir_update_* stable through T+3, rsp_valid=0100 at T+4.
REQ-032 Fairness: req_valid=1111 held constant with directory completing each op at T+3 -> grants in order 0,1,2,3,0, one every 5 cycles.
REQ-033 Timeout: lookup issued and directory never responds -> rsp_valid pulse after TIMEOUT_CYCLES WAIT cycles (default 15) with rsp_err=1, state=0, vectors=0.
REQ-034 Wrong completion: update in flight and dir_lookup_valid pulses -> no response; subsequent dir_update_done -> rsp_valid with the captured update values.
REQ-035 Reset in WAIT: rst_n pulsed low then released, late dir_lookup_valid arrives -> no rsp_valid; next req_valid=1111 grants requester 0.

Source files
------------

// File: rtl/dir_arbiter_if.sv
// -----------------------------------------------------------------------------
// dir_arbiter_if
// Bundles every requester, response and directory signal of the directory
// arbiter into one interface.
//   slave  : view used by the arbiter itself (requests/completions in,
//            grants/responses/commands out).
//   master : view used by the environment driving the arbiter (requesters
//            plus directory model).
// Signals:
//   req_valid[4], req_op[4], req_addr[128], req_state[12],
//   req_presence[16], req_tip[16]     : per-requester request payload
//   req_ready[4]                      : per-requester accept strobe
//   rsp_valid[4], rsp_state[3], rsp_presence[4], rsp_tip[4], rsp_err
//                                     : response pulse + shared payload
//   dir_lookup_req, dir_update_req, dir_lookup_addr, dir_update_addr,
//   dir_update_state, dir_update_presence, dir_update_tip
//                                     : directory command port
//   dir_lookup_valid, dir_update_done, dir_lookup_state,
//   dir_lookup_presence, dir_lookup_tip
//                                     : directory completion port
// -----------------------------------------------------------------------------
interface dir_arbiter_if;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_op;
  logic [127:0] req_addr;
  logic [11:0]  req_state;
  logic [15:0]  req_presence;
  logic [15:0]  req_tip;

  logic [3:0]   rsp_valid;
  logic [2:0]   rsp_state;
  logic [3:0]   rsp_presence;
  logic [3:0]   rsp_tip;
  logic         rsp_err;

  logic         dir_lookup_req;
  logic         dir_update_req;
  logic [31:0]  dir_lookup_addr;
  logic [31:0]  dir_update_addr;
  logic [2:0]   dir_update_state;
  logic [3:0]   dir_update_presence;
  logic [3:0]   dir_update_tip;

  logic         dir_lookup_valid;
  logic         dir_update_done;
  logic [2:0]   dir_lookup_state;
  logic [3:0]   dir_lookup_presence;
  logic [3:0]   dir_lookup_tip;

  modport slave (
    input  req_valid, req_op, req_addr, req_state, req_presence, req_tip,
    input  dir_lookup_valid, dir_update_done, dir_lookup_state,
           dir_lookup_presence, dir_lookup_tip,
    output req_ready, rsp_valid, rsp_state, rsp_presence, rsp_tip, rsp_err,
    output dir_lookup_req, dir_update_req, dir_lookup_addr, dir_update_addr,
           dir_update_state, dir_update_presence, dir_update_tip
  );

  modport master (
    output req_valid, req_op, req_addr, req_state, req_presence, req_tip,
    output dir_lookup_valid, dir_update_done, dir_lookup_state,
           dir_lookup_presence, dir_lookup_tip,
    input  req_ready, rsp_valid, rsp_state, rsp_presence, rsp_tip, rsp_err,
    input  dir_lookup_req, dir_update_req, dir_lookup_addr, dir_update_addr,
           dir_update_state, dir_update_presence, dir_update_tip
  );
endinterface

// File: rtl/dir_arbiter.sv
// -----------------------------------------------------------------------------
// dir_arbiter
// Round-robin arbiter that serialises four requesters onto a single directory
// lookup/update port. One operation is in flight at a time:
//   IDLE  -> grant (req_ready pulse, payload captured)
//   ISSUE -> one-cycle directory command strobe
//   WAIT  -> wait for the matching completion or time out
//   RESP  -> one-cycle rsp_valid pulse to the granted requester
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dir_arbiter_if.slave (requests, responses, directory port)
// Parameter:
//   TIMEOUT_CYCLES : WAIT cycles before an operation is aborted (4..255)
// -----------------------------------------------------------------------------
module dir_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  dir_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [1:0]  r_last_grant;
  logic        r_op;
  logic [31:0] r_addr;
  logic [2:0]  r_upd_state;
  logic [3:0]  r_upd_presence;
  logic [3:0]  r_upd_tip;
  logic [7:0]  r_wait_cnt;
  logic        r_lookup_req;
  logic        r_update_req;
  logic [3:0]  r_rsp_valid;
  logic [2:0]  r_rsp_state;
  logic [3:0]  r_rsp_presence;
  logic [3:0]  r_rsp_tip;
  logic        r_rsp_err;

  logic [31:0] w_addr     [4];
  logic [2:0]  w_state    [4];
  logic [3:0]  w_presence [4];
  logic [3:0]  w_tip      [4];
  logic [3:0]  w_ready;
  logic        w_any;
  logic [1:0]  w_grant;
  logic [1:0]  w_cand;
  logic        w_done;
  logic        w_timeout;

  // Unpack the flat per-requester buses and form the accept strobes.
  // req_ready is combinational in the grant cycle and forced low in reset.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      assign w_addr[gi]     = bus.req_addr[32*gi +: 32];
      assign w_state[gi]    = bus.req_state[3*gi +: 3];
      assign w_presence[gi] = bus.req_presence[4*gi +: 4];
      assign w_tip[gi]      = bus.req_tip[4*gi +: 4];
      assign w_ready[gi]    = rst_n && (r_state == IDLE) && w_any &&
                              (w_grant == 2'(gi));
    end
  endgenerate

  // Round-robin pick: walk candidates from farthest (last_grant itself) to
  // nearest (last_grant+1) so the nearest valid requester wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = 2'd0;
    w_cand  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_last_grant + 2'(k);
      if (bus.req_valid[w_cand]) begin
        w_any   = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Only the completion that matches the in-flight op counts.
  assign w_done    = r_op ? bus.dir_update_done : bus.dir_lookup_valid;
  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_last_grant   <= 2'd3;
      r_op           <= 1'b0;
      r_addr         <= '0;
      r_upd_state    <= '0;
      r_upd_presence <= '0;
      r_upd_tip      <= '0;
      r_wait_cnt     <= '0;
      r_lookup_req   <= 1'b0;
      r_update_req   <= 1'b0;
      r_rsp_valid    <= '0;
      r_rsp_state    <= '0;
      r_rsp_presence <= '0;
      r_rsp_tip      <= '0;
      r_rsp_err      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_lookup_req <= 1'b0;
      r_update_req <= 1'b0;
      r_rsp_valid  <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last_grant   <= w_grant;
            r_op           <= bus.req_op[w_grant];
            r_addr         <= w_addr[w_grant];
            r_upd_state    <= w_state[w_grant];
            r_upd_presence <= w_presence[w_grant];
            r_upd_tip      <= w_tip[w_grant];
            // Registered so the strobe is high during the ISSUE cycle.
            r_lookup_req   <= ~bus.req_op[w_grant];
            r_update_req   <= bus.req_op[w_grant];
            r_state        <= ISSUE;
          end
        end
        ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (w_done) begin
            if (r_op) begin
              r_rsp_state    <= r_upd_state;
              r_rsp_presence <= r_upd_presence;
              r_rsp_tip      <= r_upd_tip;
            end else begin
              r_rsp_state    <= bus.dir_lookup_state;
              r_rsp_presence <= bus.dir_lookup_presence;
              r_rsp_tip      <= bus.dir_lookup_tip;
            end
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 4'b0001 << r_last_grant;
            r_state     <= RESP;
          end else if (w_timeout) begin
            // Abort: report an error with an all-zero payload.
            r_rsp_state    <= '0;
            r_rsp_presence <= '0;
            r_rsp_tip      <= '0;
            r_rsp_err      <= 1'b1;
            r_rsp_valid    <= 4'b0001 << r_last_grant;
            r_state        <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready           = w_ready;
  assign bus.rsp_valid           = r_rsp_valid;
  assign bus.rsp_state           = r_rsp_state;
  assign bus.rsp_presence        = r_rsp_presence;
  assign bus.rsp_tip             = r_rsp_tip;
  assign bus.rsp_err             = r_rsp_err;
  assign bus.dir_lookup_req      = r_lookup_req;
  assign bus.dir_update_req      = r_update_req;
  // The directory samples address and update payload after the strobe, so
  // they are driven straight from the capture registers and held until the
  // next grant.
  assign bus.dir_lookup_addr     = r_addr;
  assign bus.dir_update_addr     = r_addr;
  assign bus.dir_update_state    = r_upd_state;
  assign bus.dir_update_presence = r_upd_presence;
  assign bus.dir_update_tip      = r_upd_tip;

endmodule

// File: tb/tb_dir_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dir_arbiter
// Self-checking bench for dir_arbiter. Requesters and the directory are
// modelled procedurally; expected grants and responses come from a simple
// round-robin / transaction model kept here.
// -----------------------------------------------------------------------------
module tb_dir_arbiter;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dir_arbiter_if bus();

  dir_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int txn_id  = 0;

  // Requester payloads and directory lookup reply data.
  bit          f_op   [4];
  logic [31:0] f_addr [4];
  logic [2:0]  f_state[4];
  logic [3:0]  f_pres [4];
  logic [3:0]  f_tip  [4];
  logic [2:0]  d_state;
  logic [3:0]  d_pres;
  logic [3:0]  d_tip;

  // Model of arbitration history.
  int last_g = 3;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_grant(input logic [3:0] mask, input int last);
    for (int k = 1; k <= 4; k++)
      if (mask[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < 4; i++) begin
      bus.req_op[i]              = f_op[i];
      bus.req_addr[32*i +: 32]   = f_addr[i];
      bus.req_state[3*i +: 3]    = f_state[i];
      bus.req_presence[4*i +: 4] = f_pres[i];
      bus.req_tip[4*i +: 4]      = f_tip[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 4; i++) begin
      f_op[i]    = 1'($urandom);
      f_addr[i]  = $urandom;
      f_state[i] = 3'($urandom);
      f_pres[i]  = 4'($urandom);
      f_tip[i]   = 4'($urandom);
    end
  endtask

  task automatic rand_dir();
    d_state = 3'($urandom);
    d_pres  = 4'($urandom);
    d_tip   = 4'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_rspv"},  32'(bus.rsp_valid), 0);
    check({tag, "_rsps"},  32'(bus.rsp_state), 0);
    check({tag, "_rspp"},  32'(bus.rsp_presence), 0);
    check({tag, "_rspt"},  32'(bus.rsp_tip), 0);
    check({tag, "_rspe"},  32'(bus.rsp_err), 0);
    check({tag, "_lreq"},  32'(bus.dir_lookup_req), 0);
    check({tag, "_ureq"},  32'(bus.dir_update_req), 0);
    check({tag, "_laddr"}, bus.dir_lookup_addr, 0);
    check({tag, "_uaddr"}, bus.dir_update_addr, 0);
    check({tag, "_ust"},   32'(bus.dir_update_state), 0);
    check({tag, "_upr"},   32'(bus.dir_update_presence), 0);
    check({tag, "_utp"},   32'(bus.dir_update_tip), 0);
  endtask

  // One complete transaction starting in an IDLE cycle. The directory
  // replies on WAIT cycle 'delay' (0 = T+2, 1 = T+3) when 'respond' is set;
  // 'wrong' pulses the non-matching completion in the first WAIT cycle.
  task automatic run_txn(input logic [3:0] mask, input int delay,
                         input bit respond, input bit wrong);
    int          g;
    int          nwait;
    bit          op;
    logic [31:0] addr;
    logic [2:0]  us, es;
    logic [3:0]  up, ut, ep, et;
    int          fails_before;
    fails_before = n_fail;
    g = next_grant(mask, last_g);

    // T: grant cycle
    @(negedge clk);
    bus.req_valid = mask;
    drive_fields();
    #1;
    check("grant", 32'(bus.req_ready), 32'(4'b0001 << g));
    check("rsp_idle", 32'(bus.rsp_valid), 0);
    last_g = g;
    op = f_op[g]; addr = f_addr[g];
    us = f_state[g]; up = f_pres[g]; ut = f_tip[g];

    // T+1: command cycle; requester inputs scrambled, stray completions
    @(negedge clk);
    rand_fields();
    drive_fields();
    bus.dir_lookup_valid = 1'($urandom);
    bus.dir_update_done  = 1'($urandom);
    bus.dir_lookup_state = 3'($urandom);
    #1;
    check("issue_ready", 32'(bus.req_ready), 0);
    check("issue_lreq", 32'(bus.dir_lookup_req), 32'(!op));
    check("issue_ureq", 32'(bus.dir_update_req), 32'(op));
    check("issue_laddr", bus.dir_lookup_addr, addr);
    check("issue_uaddr", bus.dir_update_addr, addr);
    if (op) begin
      check("issue_ust", 32'(bus.dir_update_state), 32'(us));
      check("issue_upr", 32'(bus.dir_update_presence), 32'(up));
      check("issue_utp", 32'(bus.dir_update_tip), 32'(ut));
    end

    // WAIT cycles
    nwait = respond ? delay + 1 : TMO;
    for (int w = 0; w < nwait; w++) begin
      @(negedge clk);
      bus.dir_lookup_valid = 1'b0;
      bus.dir_update_done  = 1'b0;
      bus.dir_lookup_state    = 3'($urandom);
      bus.dir_lookup_presence = 4'($urandom);
      bus.dir_lookup_tip      = 4'($urandom);
      if (wrong && w == 0) begin
        if (op) bus.dir_lookup_valid = 1'b1;
        else    bus.dir_update_done  = 1'b1;
      end
      if (respond && w == delay) begin
        if (op) bus.dir_update_done = 1'b1;
        else begin
          bus.dir_lookup_valid    = 1'b1;
          bus.dir_lookup_state    = d_state;
          bus.dir_lookup_presence = d_pres;
          bus.dir_lookup_tip      = d_tip;
        end
      end
      #1;
      check("wait_ready", 32'(bus.req_ready), 0);
      check("wait_rspv", 32'(bus.rsp_valid), 0);
      check("wait_strobes", 32'({bus.dir_lookup_req, bus.dir_update_req}), 0);
      check("wait_laddr", bus.dir_lookup_addr, addr);
      check("wait_uaddr", bus.dir_update_addr, addr);
      if (op) begin
        check("wait_ust", 32'(bus.dir_update_state), 32'(us));
        check("wait_upr", 32'(bus.dir_update_presence), 32'(up));
        check("wait_utp", 32'(bus.dir_update_tip), 32'(ut));
      end
    end

    // RESP cycle
    @(negedge clk);
    bus.dir_lookup_valid = 1'b0;
    bus.dir_update_done  = 1'b0;
    #1;
    if (!respond)  begin es = 3'd0; ep = 4'd0; et = 4'd0; end
    else if (op)   begin es = us; ep = up; et = ut; end
    else           begin es = d_state; ep = d_pres; et = d_tip; end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(4'b0001 << g));
    check("rsp_state", 32'(bus.rsp_state), 32'(es));
    check("rsp_pres", 32'(bus.rsp_presence), 32'(ep));
    check("rsp_tip", 32'(bus.rsp_tip), 32'(et));
    check("rsp_err", 32'(bus.rsp_err), 32'(!respond));
    check("rsp_ready", 32'(bus.req_ready), 0);
    $display("[TB] txn %0d mask=%b grant=%0d op=%0d respond=%0d wrong=%0d delay=%0d errs=%0d",
             txn_id, mask, g, op, respond, wrong, delay, n_fail - fails_before);
    txn_id++;
  endtask

  initial begin
    int g;
    bus.req_valid = '0; bus.req_op = '0; bus.req_addr = '0;
    bus.req_state = '0; bus.req_presence = '0; bus.req_tip = '0;
    bus.dir_lookup_valid = 1'b0; bus.dir_update_done = 1'b0;
    bus.dir_lookup_state = '0; bus.dir_lookup_presence = '0;
    bus.dir_lookup_tip = '0;

    // Reset state, with requests present to show req_ready stays low.
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    repeat (2) begin
      @(negedge clk); #1;
      check_all_zero("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;

    // Directed lookup.
    rand_fields();
    f_op[0] = 1'b0; f_addr[0] = 32'h0000_1044;
    d_state = 3'd2; d_pres = 4'b0101; d_tip = 4'b0001;
    run_txn(4'b0001, 1, 1'b1, 1'b0);

    // Directed update.
    rand_fields();
    f_op[2] = 1'b1; f_addr[2] = 32'h8000_0007;
    f_state[2] = 3'd3; f_pres[2] = 4'b1000; f_tip[2] = 4'b1000;
    rand_dir();
    run_txn(4'b0100, 1, 1'b1, 1'b0);

    // Timeout on a lookup that is never answered.
    rand_fields();
    for (int i = 0; i < 4; i++) f_op[i] = 1'b0;
    run_txn(4'b0010, 0, 1'b0, 1'b0);

    // Update with a stray lookup completion first.
    rand_fields();
    for (int i = 0; i < 4; i++) f_op[i] = 1'b1;
    rand_dir();
    run_txn(4'b1000, 3, 1'b1, 1'b1);

    // Reset while waiting on a lookup.
    rand_fields();
    for (int i = 0; i < 4; i++) f_op[i] = 1'b0;
    @(negedge clk);
    bus.req_valid = 4'hF;
    drive_fields();
    g = next_grant(4'hF, last_g);
    #1;
    check("rst_grant", 32'(bus.req_ready), 32'(4'b0001 << g));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk); #1;
    check_all_zero("midrst2");
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
    last_g = 3;
    @(negedge clk);
    bus.dir_lookup_valid = 1'b1;
    #1;
    check("late_cpl_rspv", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    bus.dir_lookup_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("late_cpl_quiet", 32'({bus.rsp_valid, bus.dir_lookup_req,
                                   bus.dir_update_req}), 0);
      @(negedge clk);
    end

    // Fairness: all four requesting; first grant must be requester 0.
    rand_fields();
    check("fair_first", 32'(next_grant(4'hF, last_g)), 0);
    for (int n = 0; n < 8; n++) begin
      rand_fields();
      rand_dir();
      run_txn(4'hF, 1, 1'b1, 1'b0);
    end

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      rand_fields();
      rand_dir();
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, TMO - 1),
              ($urandom % 8) != 0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
